// File: rtl/layer_compositor.sv
// layer_compositor: fixed-priority merge of N_LAYERS sprite/tile layers onto a
// background colour, pipelined to the 4/4/4 VGA pins with blanking kept in step.
// It also runs the game-over overlay: a flash counted in frames, then a solid hold.
// Optional feature macro: LAYER_COMPOSITOR_BLEND_EN. When it is defined, a
// translucent winning layer is averaged with the next enabled layer below it.
// When it is not defined, blend_mask is ignored and no blend adders are built.
module layer_compositor #(
  parameter int          N_LAYERS     = 6,
  parameter int          PIPE_STAGES  = 2,
  parameter logic [11:0] BG_RGB       = 12'h69C,
  parameter logic [11:0] OVERLAY_RGB  = 12'h0F0,
  parameter int          FLASH_PERIOD = 15,
  parameter int          FLASH_COUNT  = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  bright,
  input  logic                  frame_start,
  input  logic [N_LAYERS-1:0]   layer_en,
  input  logic [12*N_LAYERS-1:0] layer_rgb,
  input  logic [N_LAYERS-1:0]   blend_mask,
  input  logic                  game_over,
  output logic [3:0]            vgaR,
  output logic [3:0]            vgaG,
  output logic [3:0]            vgaB,
  output logic                  bright_out,
  output logic                  overlay_on
);

  // Reject out-of-range configurations at elaboration.
  if (N_LAYERS < 2 || N_LAYERS > 16) begin : g_bad_layers
    $error("layer_compositor: N_LAYERS must be 2..16");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_pipe
    $error("layer_compositor: PIPE_STAGES must be 1..3");
  end
  if (FLASH_PERIOD < 1 || FLASH_PERIOD > 255) begin : g_bad_period
    $error("layer_compositor: FLASH_PERIOD must be 1..255");
  end
  if (FLASH_COUNT < 1 || FLASH_COUNT > 255) begin : g_bad_count
    $error("layer_compositor: FLASH_COUNT must be 1..255");
  end

  localparam int         IW      = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam logic [7:0] PERIOD8 = 8'(FLASH_PERIOD);
  localparam logic [7:0] COUNT8  = 8'(FLASH_COUNT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLASH = 2'd1,
    HOLD  = 2'd2
  } ovl_state_t;

  ovl_state_t     state;
  logic [7:0]     frame_cnt;
  logic [7:0]     flash_cnt;
  logic           phase;

  logic           win_found;
  logic [IW-1:0]  win_idx;
  logic [11:0]    comp_rgb;
  logic           ovl_sel;
  logic [11:0]    stage1_rgb;

  logic [11:0]    pix_q    [PIPE_STAGES];
  logic           bright_q [PIPE_STAGES];

  // Priority compositor: lowest enabled index wins, background when none is enabled.
  // NOTE: every signal driven here gets a default before any condition so no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (layer_en[i]) begin
        win_found = 1'b1;
        win_idx   = IW'(i);
      end
    end
    comp_rgb = win_found ? layer_rgb[12*win_idx +: 12] : BG_RGB;
  end

`ifdef LAYER_COMPOSITOR_BLEND_EN
  logic           sub_found;
  logic [IW-1:0]  sub_idx;
  logic [11:0]    win_rgb;
  logic [11:0]    sub_rgb;
  logic [4:0]     sum_r;
  logic [4:0]     sum_g;
  logic [4:0]     sum_b;
  logic [11:0]    mixed_rgb;

  // Translucent winner: average each channel with the next enabled layer below it.
  always_comb begin
    sub_found = 1'b0;
    sub_idx   = '0;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (layer_en[i] && (i > int'(win_idx))) begin
        sub_found = 1'b1;
        sub_idx   = IW'(i);
      end
    end
    win_rgb   = layer_rgb[12*win_idx +: 12];
    sub_rgb   = layer_rgb[12*sub_idx +: 12];
    sum_r     = {1'b0, win_rgb[11:8]} + {1'b0, sub_rgb[11:8]};
    sum_g     = {1'b0, win_rgb[7:4]}  + {1'b0, sub_rgb[7:4]};
    sum_b     = {1'b0, win_rgb[3:0]}  + {1'b0, sub_rgb[3:0]};
    mixed_rgb = comp_rgb;
    if (win_found && blend_mask[win_idx] && sub_found) begin
      mixed_rgb = {sum_r[4:1], sum_g[4:1], sum_b[4:1]};
    end
  end
`else
  logic [11:0] mixed_rgb;
  logic        unused_blend_mask;

  // Pure priority build: the translucency mask has no effect.
  always_comb begin
    mixed_rgb         = comp_rgb;
    unused_blend_mask = ^blend_mask;
  end
`endif

  // Stage-1 colour: blanking forces black, otherwise overlay or composited pixel.
  always_comb begin
    ovl_sel    = (state == HOLD) || ((state == FLASH) && phase);
    stage1_rgb = 12'h000;
    if (bright) begin
      stage1_rgb = ovl_sel ? OVERLAY_RGB : mixed_rgb;
    end
  end

  // Game-over overlay FSM with saturating frame and flash counters.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      frame_cnt  <= 8'd0;
      flash_cnt  <= 8'd0;
      phase      <= 1'b0;
      overlay_on <= 1'b0;
    end else begin
      overlay_on <= (state == FLASH) || (state == HOLD);
      unique case (state)
        IDLE: begin
          if (game_over) begin
            state     <= FLASH;
            frame_cnt <= 8'd0;
            flash_cnt <= 8'd0;
            phase     <= 1'b1;
          end
        end
        FLASH: begin
          if (!game_over) begin
            state     <= IDLE;
            frame_cnt <= 8'd0;
            flash_cnt <= 8'd0;
            phase     <= 1'b0;
          end else if (frame_start) begin
            if ((frame_cnt == 8'hFF) || ((frame_cnt + 8'd1) >= PERIOD8)) begin
              frame_cnt <= 8'd0;
              phase     <= ~phase;
              if (flash_cnt != 8'hFF) begin
                flash_cnt <= flash_cnt + 8'd1;
              end
              if ((flash_cnt == 8'hFF) || ((flash_cnt + 8'd1) >= COUNT8)) begin
                state <= HOLD;
              end
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        HOLD: begin
          if (!game_over) begin
            state     <= IDLE;
            frame_cnt <= 8'd0;
            flash_cnt <= 8'd0;
            phase     <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Pixel and blanking delay line; stage 0 holds the stage-1 result.
  // NOTE: the delay line is small and is reset so no stale pixel leaves after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        pix_q[i]    <= 12'h000;
        bright_q[i] <= 1'b0;
      end
    end else begin
      pix_q[0]    <= stage1_rgb;
      bright_q[0] <= bright;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        pix_q[i]    <= pix_q[i-1];
        bright_q[i] <= bright_q[i-1];
      end
    end
  end

  assign vgaR       = pix_q[PIPE_STAGES-1][11:8];
  assign vgaG       = pix_q[PIPE_STAGES-1][7:4];
  assign vgaB       = pix_q[PIPE_STAGES-1][3:0];
  assign bright_out = bright_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor with FLASH_PERIOD=2, FLASH_COUNT=3 and
// the remaining parameters at their defaults (6 layers, 2-cycle latency).
module tb_layer_compositor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        bright;
  logic        frame_start;
  logic [5:0]  layer_en;
  logic [71:0] layer_rgb;
  logic [5:0]  blend_mask;
  logic        game_over;
  logic [3:0]  vgaR;
  logic [3:0]  vgaG;
  logic [3:0]  vgaB;
  logic        bright_out;
  logic        overlay_on;

  int checks = 0;
  int errors = 0;

  layer_compositor #(
    .N_LAYERS    (6),
    .PIPE_STAGES (2),
    .FLASH_PERIOD(2),
    .FLASH_COUNT (3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bright     (bright),
    .frame_start(frame_start),
    .layer_en   (layer_en),
    .layer_rgb  (layer_rgb),
    .blend_mask (blend_mask),
    .game_over  (game_over),
    .vgaR       (vgaR),
    .vgaG       (vgaG),
    .vgaB       (vgaB),
    .bright_out (bright_out),
    .overlay_on (overlay_on)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] rgb();
    return {vgaR, vgaG, vgaB};
  endfunction

  task automatic set_layer(input int i, input logic [11:0] c);
    layer_rgb[12*i +: 12] = c;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One frame: a single-cycle frame_start pulse followed by idle pixels.
  task automatic frame();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(19);
  endtask

  initial begin
    reset_n     = 1'b0;
    bright      = 1'b1;
    frame_start = 1'b0;
    layer_en    = 6'b111111;
    layer_rgb   = '0;
    blend_mask  = 6'b000000;
    game_over   = 1'b0;
    set_layer(0, 12'hABC);
    #2;
    check("rst_rgb", 32'(rgb()), 32'h000);
    check("rst_ovl", 32'(overlay_on), 32'h0);
    check("rst_bright", 32'(bright_out), 32'h0);
    tick(2);
    check("rst_hold_rgb", 32'(rgb()), 32'h000);
    reset_n = 1'b1;

    // Priority: layers 2 and 5 enabled, layer 2 wins; latency is two edges.
    set_layer(0, 12'h123);
    set_layer(2, 12'hF00);
    set_layer(5, 12'h00F);
    layer_en = 6'b100100;
    tick(1);
    check("lat1_rgb", 32'(rgb()), 32'h000);
    tick(1);
    check("prio_rgb", 32'(rgb()), 32'hF00);
    check("prio_bright", 32'(bright_out), 32'h1);

    layer_en = 6'b000000;
    tick(1);
    check("bg_lat_rgb", 32'(rgb()), 32'hF00);
    tick(1);
    check("bg_rgb", 32'(rgb()), 32'h69C);

    bright = 1'b0;
    tick(2);
    check("blank_rgb", 32'(rgb()), 32'h000);
    check("blank_bright", 32'(bright_out), 32'h0);
    bright = 1'b1;

    layer_en = 6'b111111;
    tick(2);
    check("all_rgb", 32'(rgb()), 32'h123);
    layer_en = 6'b100000;
    tick(2);
    check("last_rgb", 32'(rgb()), 32'h00F);

    // Translucent top layer over black.
    set_layer(0, 12'hFFF);
    set_layer(3, 12'h000);
    blend_mask = 6'b000001;
    layer_en   = 6'b001001;
    tick(2);
`ifdef LAYER_COMPOSITOR_BLEND_EN
    check("blend_pair", 32'(rgb()), 32'h777);
`else
    check("blend_pair", 32'(rgb()), 32'hFFF);
`endif
    layer_en = 6'b000001;
    tick(2);
    check("blend_alone", 32'(rgb()), 32'hFFF);
    blend_mask = 6'b000000;

    // Game over, with a frame_start in the entry cycle that must not count.
    layer_en    = 6'b000100;
    tick(2);
    game_over   = 1'b1;
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    check("ovl_lag", 32'(overlay_on), 32'h0);
    check("entry_old_rgb", 32'(rgb()), 32'hF00);
    tick(1);
    check("ovl_on", 32'(overlay_on), 32'h1);
    check("entry_lat_rgb", 32'(rgb()), 32'hF00);
    tick(1);
    check("flash_on_rgb", 32'(rgb()), 32'h0F0);
    tick(20);
    frame();
    check("entry_not_counted", 32'(rgb()), 32'h0F0);
    frame();
    check("flash_off_a", 32'(rgb()), 32'hF00);
    frame();
    check("flash_off_b", 32'(rgb()), 32'hF00);
    frame();
    check("flash_on_a", 32'(rgb()), 32'h0F0);
    frame();
    check("flash_on_b", 32'(rgb()), 32'h0F0);
    frame();
    check("hold_rgb", 32'(rgb()), 32'h0F0);
    for (int f = 0; f < 8; f++) frame();
    check("hold_absorb_rgb", 32'(rgb()), 32'h0F0);
    check("hold_ovl", 32'(overlay_on), 32'h1);

    // Game over drops during HOLD.
    game_over = 1'b0;
    tick(1);
    check("exit_ovl_lag", 32'(overlay_on), 32'h1);
    tick(1);
    check("exit_ovl_off", 32'(overlay_on), 32'h0);
    check("exit_lat_rgb", 32'(rgb()), 32'h0F0);
    tick(1);
    check("exit_resume_rgb", 32'(rgb()), 32'hF00);

    // Asynchronous reset mid-frame while the overlay is active.
    game_over = 1'b1;
    tick(4);
    check("pre_rst_ovl", 32'(overlay_on), 32'h1);
    #2;
    reset_n   = 1'b0;
    game_over = 1'b0;
    #1;
    check("async_rst_rgb", 32'(rgb()), 32'h000);
    check("async_rst_ovl", 32'(overlay_on), 32'h0);
    check("async_rst_bright", 32'(bright_out), 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    check("post_rst_lat", 32'(rgb()), 32'h000);
    tick(1);
    check("post_rst_rgb", 32'(rgb()), 32'hF00);
    check("post_rst_ovl", 32'(overlay_on), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
